// File: rtl/mcb_memtest_engine_pkg.sv
// Shared definitions for the MCB pattern-test engine: command codes,
// FSM state encoding and the address-derived test pattern.
package memtest_pkg;

    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WR_FILL,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    // Pattern word for word index w: the index zero-extended, XOR the seed.
    // Callers truncate the result to their data width.
    function automatic logic [63:0] pattern(input logic [63:0] w, input logic [63:0] seed);
        return w ^ seed;
    endfunction

endpackage

// File: rtl/mcb_memtest_engine_sync_rise.sv
// sync_rise: 2-FF synchroniser for a slow control level from another clock
// domain, followed by a one-cycle rising-edge pulse.
module sync_rise (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [2:0] r_sync;

    // Shift the level through two metastability flops and one history flop.
    // The flops reset to 1 so a level already high at reset release is not
    // mistaken for a fresh rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/mcb_memtest_engine.sv
// mcb_memtest_engine: writes an address-derived pattern over a region of an
// MCB user port, reads it back, and reports mismatch count and first address.
module mcb_memtest_engine
    import memtest_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BL         = 16,
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned NUM_BURSTS = 1024,
    parameter logic [31:0] SEED       = 32'hA5A5_5A5A
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                calib_done,
    output logic                cmd_en,
    output logic [2:0]          cmd_instr,
    output logic [5:0]          cmd_bl,
    output logic [ADDR_W-1:0]   cmd_byte_addr,
    input  logic                cmd_full,
    output logic                wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_mask,
    input  logic                wr_full,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_empty,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                aborted,
    output logic [7:0]          err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned BW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int unsigned WW    = $clog2(BL) + 1;
    localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(BL - 1);

    state_t              r_state;
    state_t              w_next;
    logic [BW-1:0]       r_burst;
    logic [WW-1:0]       r_word;
    logic [7:0]          r_err_count;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_aborted;
    logic                w_start_rise;
    logic                w_clear;
    logic                w_abort;
    logic                w_running;
    logic                w_mismatch;
    logic [63:0]         w_word_idx;
    logic [DATA_W-1:0]   w_pattern;

    sync_rise u_start_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (start),
        .o_rise  (w_start_rise)
    );

    assign w_word_idx = 64'(r_burst) * 64'(BL) + 64'(r_word);
    assign w_pattern  = DATA_W'(pattern(w_word_idx, 64'(SEED)));
    assign w_running  = r_state inside {ST_WR_FILL, ST_WR_CMD, ST_RD_CMD, ST_RD_DATA};
    assign w_mismatch = rd_en && (rd_data != w_pattern);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and FIFO/command strobes; calibration loss overrides all.
    always_comb begin
        w_next    = r_state;
        cmd_en    = 1'b0;
        cmd_instr = INSTR_WR;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        w_clear   = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_rise) begin
                    w_clear = 1'b1;
                    w_next  = ST_WAIT_CAL;
                end
            end
            ST_WAIT_CAL: begin
                if (calib_done) w_next = ST_WR_FILL;
            end
            ST_WR_FILL: begin
                wr_en = !wr_full;
                if (wr_en && r_word == LAST_WORD) w_next = ST_WR_CMD;
            end
            ST_WR_CMD: begin
                cmd_en = !cmd_full;
                if (cmd_en) w_next = (r_burst == LAST_BURST) ? ST_RD_CMD : ST_WR_FILL;
            end
            ST_RD_CMD: begin
                cmd_instr = INSTR_RD;
                cmd_en    = !cmd_full;
                if (cmd_en) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rd_en = !rd_empty;
                if (rd_en && r_word == LAST_WORD)
                    w_next = (r_burst == LAST_BURST) ? ST_DONE : ST_RD_CMD;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_running && !calib_done) begin
            cmd_en  = 1'b0;
            wr_en   = 1'b0;
            rd_en   = 1'b0;
            w_abort = 1'b1;
            w_next  = ST_DONE;
        end
    end

    // Burst/word counters, saturating error tally, first-error address, abort flag.
    // The burst counter holds at the last burst at the end of the read phase
    // instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst          <= '0;
            r_word           <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_aborted        <= 1'b0;
        end else if (w_clear) begin
            r_burst          <= '0;
            r_word           <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_aborted        <= 1'b0;
        end else begin
            if (w_abort) r_aborted <= 1'b1;
            if (wr_en || rd_en) r_word <= (r_word == LAST_WORD) ? '0 : r_word + 1'b1;
            if (cmd_en && r_state == ST_WR_CMD)
                r_burst <= (r_burst == LAST_BURST) ? '0 : r_burst + 1'b1;
            if (rd_en && r_word == LAST_WORD && r_burst != LAST_BURST)
                r_burst <= r_burst + 1'b1;
            if (w_mismatch) begin
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                if (r_err_count == 8'd0) r_first_err_addr <= ADDR_W'(w_word_idx * 64'(BYTES));
            end
        end
    end

    assign cmd_bl         = 6'(BL - 1);
    assign cmd_byte_addr  = ADDR_W'(64'(r_burst) * 64'(BL * BYTES));
    assign wr_data        = (r_state == ST_WR_FILL) ? w_pattern : '0;
    assign wr_mask        = '0;
    assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done           = (r_state == ST_DONE);
    assign pass           = (r_state == ST_DONE) && (r_err_count == 8'd0) && !r_aborted;
    assign aborted        = r_aborted;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

endmodule
